// File: rtl/lsu_ctrl.sv
// Load/store initiator: one request at a time, single-cycle memory strobe, local extension and checks.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses at accept.
module lsu_ctrl #(
   parameter int unsigned MEM_BYTES = 4096,
   parameter int unsigned TAG_W     = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_rdata,
   output logic [TAG_W-1:0] resp_tag,
   output logic             resp_err,
   output logic             resp_is_load,
   output logic             mem_read,
   output logic             mem_write,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [2:0]       mem_funct3,
   input  logic [31:0]      mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   logic [1:0]       state_q, state_d;
   logic             we_q, we_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             err_q, err_d;

   logic funct3_bad;
   logic addr_bad;
   logic misalign;
   logic [31:0] rdata_ext;

   always_comb begin
      if (req_we) begin
         funct3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
      end else begin
         funct3_bad = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      end
   end

   // Compared at 33 bits so the whole 32-bit address range is checked without wrap.
   assign addr_bad = ({1'b0, req_addr} >= MEM_LIMIT);

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // Only the low bits of the memory word are used; the memory's own extension is ignored.
   always_comb begin
      case (funct3_q)
         3'b000:  rdata_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
         3'b001:  rdata_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
         3'b100:  rdata_ext = {24'd0, mem_rdata[7:0]};
         3'b101:  rdata_ext = {16'd0, mem_rdata[15:0]};
         default: rdata_ext = mem_rdata;
      endcase
   end

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through the case infers a latch.
      state_d  = state_q;
      we_d     = we_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      tag_d    = tag_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               tag_d    = req_tag;
               rdata_d  = 32'd0;
               err_d    = funct3_bad | addr_bad | misalign;
               state_d  = (funct3_bad | addr_bad | misalign) ? RESP : ISSUE;
            end
         end
         ISSUE: state_d = we_q ? RESP : WAIT;
         WAIT: begin
            rdata_d = rdata_ext;
            state_d = RESP;
         end
         default: begin
            if (resp_ready) state_d = IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'd0;
         addr_q   <= 32'd0;
         wdata_q  <= 32'd0;
         tag_q    <= '0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         tag_q    <= tag_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Strobes decode straight from the state register so reset kills them asynchronously.
   assign req_ready    = (state_q == IDLE);
   assign resp_valid   = (state_q == RESP);
   assign mem_read     = (state_q == ISSUE) & ~we_q;
   assign mem_write    = (state_q == ISSUE) & we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_funct3   = funct3_q;
   assign resp_rdata   = rdata_q;
   assign resp_tag     = tag_q;
   assign resp_err     = err_q;
   assign resp_is_load = (state_q == RESP) & ~we_q;

endmodule
